// File: rtl/texture_ram_pkg.sv
// Shared definitions for the texture store.
//   state_t      : load FSM encoding (IDLE / LOADING / READY)
//   NUM_CHANNELS : number of colour channels packed into a texel ({R,G,B})
//   addr_bits()  : texel address width derived from texture id and edge size
package texture_ram_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOADING = 2'd1,
    READY   = 2'd2
  } state_t;

  localparam int NUM_CHANNELS = 3;

  // Address layout is {tex_id, row, side, col}: one bit of side between row and col.
  function automatic int addr_bits(input int id_bits, input int size_bits);
    return id_bits + 2 * size_bits + 1;
  endfunction

endpackage

// File: rtl/texture_mem.sv
// Single-clock synchronous texel RAM, kept separate so it can be replaced by a
// vendor BRAM or ASIC macro.
//   clk   : clock
//   we    : write enable; wdata stored at waddr on the rising edge
//   waddr : write address
//   wdata : write data
//   re    : read enable; rdata updates only when set, otherwise holds
//   raddr : read address
//   rdata : registered read data (one-cycle latency)
// Contents are never reset.
module texture_mem
  import texture_ram_pkg::*;
#(
  parameter int DATA_BITS = 6,
  parameter int ADDR_BITS = 14
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [DATA_BITS-1:0] wdata,
  input  logic                 re,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [DATA_BITS-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [DATA_BITS-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/texture_ram.sv
// Loadable wall-texture store with a one-cycle registered lookup.
// Holds 2**TEX_ID_BITS textures x 2 sides x (2**TEX_SIZE_BITS)^2 texels, filled
// from a stream in address order {tex_id,row,side,col}, then read by the tracer.
// Ports:
//   clk, reset           : clock, asynchronous active-high reset
//   load_start           : pulse; restart the load from address 0
//   load_valid/load_data : streamed texel words
//   load_ready           : high while LOADING; a word is taken on load_valid & load_ready
//   load_done            : high while the store is READY
//   rd_req, tex_id, side, row, col : lookup request and texel coordinates
//   rd_valid             : rd_req delayed one cycle
//   rd_val               : texel {R,G,B}; black unless the lookup was issued while READY
// Build option: TEXTURE_SIDE_SHADE_EN halves every channel of side-1 texels
// (per-channel shift, no borrow across channels) without changing latency.
module texture_ram
  import texture_ram_pkg::*;
#(
  parameter int CHANNEL_BITS  = 2,
  parameter int TEX_SIZE_BITS = 6,
  parameter int TEX_ID_BITS   = 1
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    load_start,
  input  logic                                    load_valid,
  input  logic [NUM_CHANNELS*CHANNEL_BITS-1:0]    load_data,
  output logic                                    load_ready,
  output logic                                    load_done,
  input  logic                                    rd_req,
  input  logic [TEX_ID_BITS-1:0]                  tex_id,
  input  logic                                    side,
  input  logic [TEX_SIZE_BITS-1:0]                row,
  input  logic [TEX_SIZE_BITS-1:0]                col,
  output logic                                    rd_valid,
  output logic [NUM_CHANNELS*CHANNEL_BITS-1:0]    rd_val
);

  localparam int DATA_BITS = NUM_CHANNELS * CHANNEL_BITS;
  localparam int ADDR_BITS = addr_bits(TEX_ID_BITS, TEX_SIZE_BITS);

  state_t                 state;
  logic [ADDR_BITS-1:0]   wr_ptr;
  logic                   wr_en;
  logic                   rd_en;
  logic [ADDR_BITS-1:0]   rd_addr;
  logic [DATA_BITS-1:0]   rdata_p1;
  logic                   rd_vld_p1;
  logic                   rd_blank_p1;

`ifdef TEXTURE_SIDE_SHADE_EN
  logic                   rd_side_p1;

  function automatic logic [DATA_BITS-1:0] shade_half(input logic [DATA_BITS-1:0] t);
    logic [DATA_BITS-1:0] r;
    r = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      r[c*CHANNEL_BITS +: CHANNEL_BITS] = t[c*CHANNEL_BITS +: CHANNEL_BITS] >> 1;
    end
    return r;
  endfunction
`endif

  // Restart has priority: a word presented with load_start is dropped.
  assign wr_en   = (state == LOADING) && load_valid && !load_start;
  assign rd_addr = {tex_id, row, side, col};
  // Reads only touch the RAM while READY, so they never collide with writes.
  assign rd_en   = rd_req && (state == READY);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      load_ready <= 1'b0;
      load_done  <= 1'b0;
    end else begin
      case (state)
        IDLE, READY: begin
          if (load_start) begin
            state      <= LOADING;
            wr_ptr     <= '0;
            load_ready <= 1'b1;
            load_done  <= 1'b0;
          end
        end
        LOADING: begin
          if (load_start) begin
            wr_ptr <= '0;
          end else if (load_valid) begin
            if (&wr_ptr) begin
              state      <= READY;
              wr_ptr     <= '0;
              load_ready <= 1'b0;
              load_done  <= 1'b1;
            end else begin
              wr_ptr <= wr_ptr + 1'b1;
            end
          end
        end
        default: begin
          state      <= IDLE;
          wr_ptr     <= '0;
          load_ready <= 1'b0;
          load_done  <= 1'b0;
        end
      endcase
    end
  end

  texture_mem #(
    .DATA_BITS (DATA_BITS),
    .ADDR_BITS (ADDR_BITS)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (load_data),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (rdata_p1)
  );

  // ---- stage p0 -> p1: lookup qualifiers registered alongside the RAM read ----
  // Qualifiers only move on rd_req so that rd_val holds between requests,
  // matching the RAM output which is also read-enabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_vld_p1   <= 1'b0;
      rd_blank_p1 <= 1'b1;
`ifdef TEXTURE_SIDE_SHADE_EN
      rd_side_p1  <= 1'b0;
`endif
    end else begin
      rd_vld_p1 <= rd_req;
      if (rd_req) begin
        rd_blank_p1 <= (state != READY);
`ifdef TEXTURE_SIDE_SHADE_EN
        rd_side_p1  <= side;
`endif
      end
    end
  end

  assign rd_valid = rd_vld_p1;

`ifdef TEXTURE_SIDE_SHADE_EN
  assign rd_val = rd_blank_p1 ? '0 : (rd_side_p1 ? shade_half(rdata_p1) : rdata_p1);
`else
  assign rd_val = rd_blank_p1 ? '0 : rdata_p1;
`endif

endmodule
